afe_spi_arbiter: RTL

Shares the two write-only AFE serial-control buses (per-bus SPI clock, data and latch-enable) among several on-chip requesters, such as the CSR path from the processor and an automatic attenuation loop. It arbitrates round-robin, serialises one word per transaction MSB-first, and pulses the addressed bus's latch enable. It sits in the `sysClk` domain between those requesters and the `AFE_SPI_CLK/SDI/LE` board outputs.

---
 rtl/afe_spi_pkg.sv | 5 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/afe_spi_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/afe_spi_pkg.sv
// afe_spi_pkg: FSM encoding and bus count shared by the AFE SPI arbiter files.
package afe_spi_pkg;
   localparam int NUM_BUS = 2;
   typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, GAP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin one-hot grant starting after the last winner.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IW-1:0]      last,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      idx
);
   logic [IW-1:0] j;
   logic          found;
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         j = IW'((int'(last) + k) % NUM_REQ);
         if (!found && valid[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = j;
         end
      end
   end
endmodule

// File: rtl/afe_spi_arbiter.sv
// afe_spi_arbiter: round-robin sharing of two write-only AFE SPI buses,
// one MSB-first word per transaction followed by a latch pulse and a gap.
module afe_spi_arbiter
   import afe_spi_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int WORD_WIDTH = 16,
   parameter int CLK_DIV    = 25
) (
   input  logic                          sysClk,
   input  logic                          sysRst_n,
   input  logic [NUM_REQ-1:0]            reqValid,
   input  logic [NUM_REQ-1:0]            reqBus,
   input  logic [NUM_REQ*WORD_WIDTH-1:0] reqData,
   output logic [NUM_REQ-1:0]            reqReady,
   output logic [NUM_REQ-1:0]            reqDone,
   output logic                          busy,
   output logic [NUM_BUS-1:0]            AFE_SPI_CLK,
   output logic [NUM_BUS-1:0]            AFE_SPI_SDI,
   output logic [NUM_BUS-1:0]            AFE_SPI_LE
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(CLK_DIV + 1);
   localparam int BW = $clog2(WORD_WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);

   state_t                state, state_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic [BW-1:0]         bit_idx, bit_idx_n;
   logic [WORD_WIDTH-1:0] sh, sh_n;
   logic                  sel, sel_n, phase_end;
   logic [IW-1:0]         last, last_n, gidx;
   logic [NUM_REQ-1:0]    grant;
   logic [NUM_BUS-1:0]    bus_oh;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
      .valid(reqValid),
      .last (last),
      .grant(grant),
      .idx  (gidx)
   );

   assign reqReady = (state == IDLE) ? grant : '0;

   always_comb begin
      state_n   = state;
      cnt_n     = '0;
      bit_idx_n = bit_idx;
      sh_n      = sh;
      sel_n     = sel;
      last_n    = last;
      phase_end = (cnt == LAST_CNT);
      if (state != IDLE && !phase_end) cnt_n = cnt + CW'(1);
      case (state)
         IDLE: if (|reqReady) begin
            state_n   = SHIFT_LO;
            last_n    = gidx;
            sel_n     = reqBus[gidx];
            sh_n      = reqData[int'(gidx)*WORD_WIDTH +: WORD_WIDTH];
            bit_idx_n = BW'(WORD_WIDTH - 1);
         end
         SHIFT_LO: if (phase_end) state_n = SHIFT_HI;
         SHIFT_HI: if (phase_end) begin
            if (bit_idx == '0) state_n = LATCH;
            else begin
               state_n   = SHIFT_LO;
               bit_idx_n = bit_idx - BW'(1);
               sh_n      = sh << 1;
            end
         end
         LATCH: if (phase_end) state_n = GAP;
         GAP: if (phase_end) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      bus_oh = NUM_BUS'(1) << sel_n;
   end

   // Outputs are decoded from the next state so they line up with it after the edge.
   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         sh          <= '0;
         sel         <= 1'b0;
         last        <= IW'(NUM_REQ - 1);
         busy        <= 1'b0;
         reqDone     <= '0;
         AFE_SPI_CLK <= '0;
         AFE_SPI_SDI <= '0;
         AFE_SPI_LE  <= '0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         bit_idx     <= bit_idx_n;
         sh          <= sh_n;
         sel         <= sel_n;
         last        <= last_n;
         busy        <= (state_n != IDLE);
         reqDone     <= (state_n == GAP && cnt_n == LAST_CNT) ? NUM_REQ'(1) << last_n : '0;
         AFE_SPI_CLK <= (state_n == SHIFT_HI) ? bus_oh : '0;
         AFE_SPI_SDI <= ((state_n == SHIFT_LO || state_n == SHIFT_HI) && sh_n[WORD_WIDTH-1]) ? bus_oh : '0;
         AFE_SPI_LE  <= (state_n == LATCH) ? bus_oh : '0;
      end
   end
endmodule
